block_normalizer: RTL

//  Block-floating-point normaliser; the inverse of fixed scaling. Buffers a frame
//  of BLOCK_SIZE signed samples and finds the common count of redundant sign bits.

---
 rtl/block_normalizer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/block_normalizer.sv
// Block-floating-point normaliser.
// Buffers a frame of BLOCK_SIZE signed samples and tracks the smallest count of
// redundant sign bits across the frame. It then replays the frame shifted left
// by that common count, which is reported on `exponent`. Because the shift never
// exceeds the headroom of any sample in the frame, the replay is lossless.
module block_normalizer #(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 16,
    parameter int MAX_SHIFT  = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last,
    output logic [$clog2(DATA_WIDTH)-1:0] exponent
);

    localparam int EW = $clog2(DATA_WIDTH);
    localparam int PW = $clog2(BLOCK_SIZE);
    localparam logic [EW-1:0] MAX_SH   = EW'(MAX_SHIFT);
    localparam logic [PW-1:0] LAST_PTR = PW'(BLOCK_SIZE - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Number of consecutive bits directly below the MSB that equal the MSB.
    function automatic logic [EW-1:0] redundant_sign(input logic signed [DATA_WIDTH-1:0] x);
        logic [EW-1:0] cnt;
        logic          run;
        cnt = '0;
        run = 1'b1;
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            if (run && (x[i] == x[DATA_WIDTH-1])) begin
                cnt = cnt + EW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic logic [EW-1:0] min_u(input logic [EW-1:0] a, input logic [EW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t                        state_q, state_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]                 min_q, min_d;
    logic [EW-1:0]                 exponent_q, exponent_d;
    logic                          wr_en;
    logic [EW-1:0]                 rs_in;
    logic signed [DATA_WIDTH-1:0]  din_s;
    logic signed [DATA_WIDTH-1:0]  rd_sample;
    logic signed [DATA_WIDTH-1:0]  mem_q [BLOCK_SIZE];

    assign din_s     = din;
    assign rd_sample = mem_q[rd_ptr_q];

    // Ready is forced low while reset is held, even though the state is FILL.
    assign din_ready  = (state_q == S_FILL) && rst_n;
    assign dout_valid = (state_q == S_DRAIN);
    assign dout_last  = dout_valid && (rd_ptr_q == LAST_PTR);
    assign dout       = dout_valid ? (rd_sample <<< exponent_q) : '0;
    assign exponent   = exponent_q;

    // Next-state logic: accumulate the frame minimum while filling, step the read pointer while draining.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        min_d      = min_q;
        exponent_d = exponent_q;
        wr_en      = 1'b0;
        rs_in      = redundant_sign(din_s);
        case (state_q)
            S_FILL: begin
                if (din_valid && din_ready) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        exponent_d = min_u(min_u(min_q, rs_in), MAX_SH);
                        wr_ptr_d   = '0;
                        min_d      = MAX_SH;
                        state_d    = S_DRAIN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        min_d    = min_u(min_q, rs_in);
                    end
                end
            end
            S_DRAIN: begin
                if (dout_ready) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        rd_ptr_d = '0;
                        state_d  = S_FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Control registers; the exponent resets to zero and the running minimum to the shift cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            min_q      <= MAX_SH;
            exponent_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            min_q      <= min_d;
            exponent_q <= exponent_d;
        end
    end

    // Frame buffer; contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_s;
        end
    end

endmodule
